// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives the raw PS/2 keyboard stream (scan code set 2), deframes the
//   11-bit frames, resolves the E0 (extended) and F0 (break) prefixes and
//   emits one-cycle key events in the clk_sys domain.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock pin (asynchronous)
//   ps2_data     in   raw PS/2 data pin (asynchronous)
//   key_strobe   out  one-cycle pulse, new key event valid
//   key_code     out  scan code with prefixes stripped, held until next strobe
//   key_pressed  out  1 = make, 0 = break, held
//   key_extended out  1 = E0 prefix preceded the code, held
//   frame_err    out  one-cycle pulse on start/stop/parity/timeout error
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, a bad odd-parity bit rejects the byte
//                        and pulses frame_err; otherwise parity is ignored.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ---- stage: pin synchronizers and clock glitch filter ----
    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] filt_sh_q;
    logic                  filt_q, filt_d;
    logic                  clk_s, dat_s, all_lo, all_hi, fall;

    assign clk_s  = clk_sync_q[1];
    assign dat_s  = dat_sync_q[1];
    assign all_lo = ~|filt_sh_q;
    assign all_hi = &filt_sh_q;
    assign fall   = filt_q & all_lo;

    always_comb begin
        filt_d = filt_q;
        if (all_lo)      filt_d = 1'b0;
        else if (all_hi) filt_d = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_sh_q  <= '1;
            filt_q     <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            filt_sh_q  <= {filt_sh_q[FILTER_LEN-2:0], clk_s};
            filt_q     <= filt_d;
        end
    end

    // ---- stage: frame FSM and inactivity timeout ----
    logic [1:0]       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]       shift_q, shift_d, byte_q;
    logic             par_q, par_d;
    logic             acc_q, acc_d, err_d, stop_ok;

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data bits plus parity bit hold an odd number of ones.
    assign stop_ok = dat_s & (^{shift_q, par_q});
`else
    assign stop_ok = dat_s;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        to_cnt_d = to_cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        acc_d    = 1'b0;
        err_d    = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};   // LSB arrives first
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (stop_ok) acc_d = 1'b1;
                    else         err_d = 1'b1;
                end
            endcase
        end else if (state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = S_IDLE;
            to_cnt_d = '0;
            err_d    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            to_cnt_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            to_cnt_q <= to_cnt_d;
            acc_q    <= acc_d;
        end
    end

    // Frame payload needs no reset: it is only consumed behind acc_q.
    always_ff @(posedge clk_sys) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        if (acc_d) byte_q <= shift_d;
    end

    // ---- stage: prefix resolution and key event outputs ----
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       strobe_q, strobe_d, pressed_q, pressed_d, extout_q, extout_d;
    logic       err_q;
    logic [7:0] code_q, code_d;

    // A strobe follows acceptance by one cycle with the FSM already in IDLE,
    // and the filter cannot produce another falling edge that soon, so no
    // error source can coincide with a strobe.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        strobe_d  = 1'b0;
        code_d    = code_q;
        pressed_d = pressed_q;
        extout_d  = extout_q;
        if (acc_q) begin
            case (byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                // Keyboard replies and error codes, not keys.
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    strobe_d  = 1'b1;
                    code_d    = byte_q;
                    pressed_d = ~brk_q;
                    extout_d  = ext_q;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            strobe_q  <= 1'b0;
            code_q    <= 8'h00;
            pressed_q <= 1'b0;
            extout_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            strobe_q  <= strobe_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
            extout_q  <= extout_d;
            err_q     <= err_d;
        end
    end

    assign key_strobe   = strobe_q;
    assign key_code     = code_q;
    assign key_pressed  = pressed_q;
    assign key_extended = extout_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder. The PS/2 bit period is scaled to 80 clk_sys
// cycles and the timeout shortened so the whole run stays short.
module tb_ps2_key_decoder;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    typedef struct packed {
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe, key_pressed, key_extended, frame_err;
    logic [7:0] key_code;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .key_extended(key_extended),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  vectors = 0, miscompares = 0;
    int  err_seen = 0, strobe_seen = 0;
    int  strobe_cyc = -1, stop_fall_cyc = -1;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];
    ev_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_strobe && frame_err) begin
                vectors++; miscompares++;
                $display("FAIL strobe_err_overlap: both high at cycle %0d, required exclusive", cyc);
            end
            if (key_strobe) begin
                strobe_seen++;
                strobe_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe: code=%h pressed=%b ext=%b, required none",
                             key_code, key_pressed, key_extended);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({key_code, key_pressed, key_extended} !== {mon_e.code, mon_e.pressed, mon_e.ext}) begin
                        miscompares++;
                        $display("FAIL event: got code=%h pressed=%b ext=%b, required code=%h pressed=%b ext=%b",
                                 key_code, key_pressed, key_extended, mon_e.code, mon_e.pressed, mon_e.ext);
                    end
                end
            end
            if (frame_err) err_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic p, input logic e);
        ev_t ev;
        ev.code = c; ev.pressed = p; ev.ext = e;
        exp_q.push_back(ev);
    endtask

    // Device-side frame: data changes while clock is high, sampled on fall.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_v, input int nbits);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic drain(input string name);
        tick(30);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_pending: %0d expected events never strobed, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(5);
        vectors++;
        if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_strobe: got %b required 0", key_strobe); end
        vectors++;
        if (key_code !== 8'h00) begin miscompares++; $display("FAIL rst_code: got %h required 00", key_code); end
        vectors++;
        if (key_pressed !== 1'b0) begin miscompares++; $display("FAIL rst_pressed: got %b required 0", key_pressed); end
        vectors++;
        if (key_extended !== 1'b0) begin miscompares++; $display("FAIL rst_ext: got %b required 0", key_extended); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b required 0", frame_err); end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(20);
        vectors++;
        if (err_seen !== 0) begin miscompares++; $display("FAIL rst_idle_err: got %0d errors required 0", err_seen); end
    endtask

    task automatic test_make;
        int e0;
        e0 = err_seen;
        expect_ev(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        drain("make");
        // 2 sync flops + FILTER_LEN filter samples, then accept and strobe.
        vectors++;
        if (strobe_cyc - stop_fall_cyc !== FL + 4) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles required %0d", strobe_cyc - stop_fall_cyc, FL + 4);
        end
        vectors++;
        if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL make_err: got %0d required 0", err_seen - e0); end
        vectors++;
        if (key_code !== 8'h1C) begin miscompares++; $display("FAIL make_hold: got %h required 1C", key_code); end
    endtask

    task automatic test_break;
        int s0;
        s0 = strobe_seen;
        send(8'hF0);
        tick(30);
        vectors++;
        if (strobe_seen - s0 !== 0) begin miscompares++; $display("FAIL f0_alone: got %0d strobes required 0", strobe_seen - s0); end
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        drain("break");
        vectors++;
        if (key_pressed !== 1'b0) begin miscompares++; $display("FAIL break_hold: got %b required 0", key_pressed); end
    endtask

    task automatic test_extended;
        expect_ev(8'h75, 1'b1, 1'b1);
        expect_ev(8'h75, 1'b0, 1'b1);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        drain("extended");
        vectors++;
        if (key_extended !== 1'b1) begin miscompares++; $display("FAIL ext_hold: got %b required 1", key_extended); end
    endtask

    task automatic test_drop;
        // AA clears the pending break prefix and is itself not a key.
        expect_ev(8'h1C, 1'b1, 1'b0);
        send(8'hF0); send(8'hAA); send(8'h1C);
        drain("drop");
    endtask

    task automatic test_parity;
        int e0, s0;
        e0 = err_seen;
        s0 = strobe_seen;
`ifdef PS2_PARITY_CHECK_EN
        // The rejected byte must leave the F0 prefix pending.
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        tick(30);
        vectors++;
        if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL parity_err: got %0d required 1", err_seen - e0); end
        vectors++;
        if (strobe_seen - s0 !== 0) begin miscompares++; $display("FAIL parity_strobe: got %0d required 0", strobe_seen - s0); end
        send(8'h1C);
        drain("parity");
`else
        expect_ev(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        drain("parity");
        vectors++;
        if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL parity_err: got %0d required 0", err_seen - e0); end
        vectors++;
        if (strobe_seen - s0 !== 1) begin miscompares++; $display("FAIL parity_strobe: got %0d required 1", strobe_seen - s0); end
`endif
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_seen;
        send_frame(8'h55, 1'b0, 1'b1, 5);
        tick(TO / 2);
        vectors++;
        if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL timeout_early: got %0d required 0", err_seen - e0); end
        tick(TO);
        vectors++;
        if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL timeout_err: got %0d required 1", err_seen - e0); end
        expect_ev(8'h2B, 1'b1, 1'b0);
        send(8'h2B);
        drain("timeout");
    endtask

    task automatic test_glitch_stop;
        int e0, s0;
        e0 = err_seen;
        s0 = strobe_seen;
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(50);
        vectors++;
        if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d required 0", err_seen - e0); end
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        tick(30);
        vectors++;
        if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL stop_err: got %0d required 1", err_seen - e0); end
        vectors++;
        if (strobe_seen - s0 !== 0) begin miscompares++; $display("FAIL stop_strobe: got %0d required 0", strobe_seen - s0); end
    endtask

    task automatic test_reset_midframe;
        send_frame(8'hFF, 1'b0, 1'b1, 5);
        tick(2);
        reset_n = 1'b0;
        tick(3);
        vectors++;
        if (key_code !== 8'h00) begin miscompares++; $display("FAIL midrst_code: got %h required 00", key_code); end
        reset_n = 1'b1;
        tick(20);
        expect_ev(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        drain("midreset");
    endtask

    task automatic test_back_to_back;
        int e0;
        e0 = err_seen;
        expect_ev(8'h1C, 1'b1, 1'b0);
        expect_ev(8'h32, 1'b1, 1'b0);
        expect_ev(8'h21, 1'b0, 1'b1);
        send(8'h1C); send(8'h32); send(8'hE0); send(8'hF0); send(8'h21);
        drain("b2b");
        vectors++;
        if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL b2b_err: got %0d required 0", err_seen - e0); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_drop();
        test_parity();
        test_timeout();
        test_glitch_stop();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives the raw PS/2 keyboard serial stream (device-clocked, scan code set 2).
- Deframes bytes and resolves E0 (extended) and F0 (break) prefixes.
- Emits one-cycle key events (key_strobe, key_code, key_pressed, key_extended) in clk_sys domain.
- Sits between the board PS/2 pins and the keyboard matrix mapper.

Parameters:
FILTER_LEN, 8, consecutive agreeing ps2_clk samples required before the filtered clock changes level
TIMEOUT_CYCLES, 24000, clk_sys cycles without a falling edge before a partial frame is abandoned (~1 ms at 24 MHz)

Ports:
clk_sys  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
ps2_data  input  1  raw PS/2 data from pin, asynchronous
key_strobe  output  1  one-cycle pulse: new key event valid
key_code  output  8  scan code byte, prefixes stripped; held until next strobe
key_pressed  output  1  1 = make, 0 = break (F0 seen); held
key_extended  output  1  1 = E0 prefix seen; held
frame_err  output  1  one-cycle pulse on framing/parity/timeout error

Behaviour:
- Reset: key_strobe=0, key_code=8'h00, key_pressed=0, key_extended=0, frame_err=0. Prefix flags cleared, FSM in IDLE, filter output=1. Reset mid-frame discards the partial byte.
- Input sync: both pins pass through 2-flop synchronizers.
- Clock filter: FILTER_LEN-deep shift of synced ps2_clk. Filtered clock goes 0 only when all samples are 0 and goes 1 only when all are 1. A falling edge is a filtered 1->0 transition. Data is sampled from synced ps2_data on that cycle.
- Frame FSM, advanced only on falling edges:
  - IDLE: data=0 -> DATA, bit count=0. Data=1 -> stay IDLE and pulse frame_err.
  - DATA: shift in LSB first; after 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: data=1 and odd parity correct -> byte accepted. Otherwise pulse frame_err. Always -> IDLE.
- Timeout: counter cleared on each falling edge and while in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err for one cycle. Prefix flags are kept.
- Byte interpretation on the cycle after acceptance:
  - E0: set ext flag, no strobe.
  - F0: set brk flag, no strobe.
  - AA, FA, EE, FE, 00, FF: dropped, both flags cleared, no strobe.
  - Any other byte: key_code=byte, key_pressed=~brk, key_extended=ext, key_strobe=1 for one cycle; both flags cleared.
- Latency: key_strobe rises exactly 2 clk_sys cycles after the cycle the stop-bit falling edge is detected.
- key_strobe and frame_err are never asserted in the same cycle.
- Back-to-back frames with minimum PS/2 spacing must not lose bytes.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: a parity mismatch in STOP rejects the byte, pulses frame_err and leaves prefix flags unchanged.
- Undefined: the parity bit is captured but ignored; only stop-bit and timeout errors pulse frame_err.

Test Plan:
- Frame 1C (parity 0, stop 1) at 12.5 kHz -> single key_strobe, key_code=1C, key_pressed=1, key_extended=0.
- Frames F0,1C -> one strobe, key_code=1C, key_pressed=0, key_extended=0; no strobe after F0 alone.
- Frames E0,75 then E0,F0,75 -> strobes (75,pressed=1,ext=1) then (75,pressed=0,ext=1).
- Frame 1C with parity bit flipped -> with PS2_PARITY_CHECK_EN: frame_err pulse, no strobe. Without it: strobe with code 1C.
- Start bit plus 4 data bits then clock idle high -> frame_err after TIMEOUT_CYCLES; a following frame 2B yields strobe, code 2B.
- ps2_clk low glitch of 3 clk_sys cycles (< FILTER_LEN) mid-idle -> no FSM change, no frame_err; stop bit=0 on a 1C frame -> frame_err, no strobe.
